// File: rtl/crc32_24_stream_if.sv
// Streaming interface for the 24-bit-word CRC-32 engine.
// Carries the input word handshake and the per-frame CRC result handshake.
interface crc32_24_stream_if;
    logic        s_valid_i;
    logic        s_ready_o;
    logic [23:0] s_data_i;
    logic        s_last_i;
    logic [1:0]  s_nbytes_i;
    logic        m_valid_o;
    logic        m_ready_i;
    logic [31:0] m_crc_o;

    // Word/CRC producer-consumer side (testbench or surrounding logic).
    modport master (
        output s_valid_i, s_data_i, s_last_i, s_nbytes_i, m_ready_i,
        input  s_ready_o, m_valid_o, m_crc_o
    );

    // CRC engine side.
    modport slave (
        input  s_valid_i, s_data_i, s_last_i, s_nbytes_i, m_ready_i,
        output s_ready_o, m_valid_o, m_crc_o
    );
endinterface

// File: rtl/crc32_24_stream.sv
// Streaming CRC-32 (poly 0x04C11DB7, MSB-first, non-reflected) over 24-bit words.
// Full words advance the CRC in one cycle; a 1- or 2-byte final word is absorbed
// one bit per cycle by a tail shifter. One CRC per frame is presented on a
// valid/ready output and held until taken.
module crc32_24_stream #(
    parameter logic [31:0] INIT   = 32'hFFFFFFFF,
    parameter logic [31:0] XOROUT = 32'hFFFFFFFF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    crc32_24_stream_if.slave  bus
);

    localparam logic [31:0] POLY = 32'h04C11DB7;

    typedef enum logic [1:0] {
        S_ACCUM = 2'd0,
        S_TAIL  = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // One bit of the CRC register update, first-on-the-wire bit order.
    function automatic logic [31:0] crc32_bit(input logic [31:0] crc, input logic b);
        crc32_bit = {crc[30:0], 1'b0} ^ ((crc[31] ^ b) ? POLY : 32'h0000_0000);
    endfunction

    // Full 24-bit word update: bit 23 enters the register first.
    function automatic logic [31:0] crc32_24(input logic [31:0] crc, input logic [23:0] data);
        logic [31:0] c;
        logic [23:0] d;
        c = crc;
        d = data;
        for (int i = 0; i < 24; i++) begin
            c = crc32_bit(c, d[23]);
            d = {d[22:0], 1'b0};
        end
        crc32_24 = c;
    endfunction

    state_t      r_state;
    state_t      w_state_nx;
    logic [31:0] r_crc;
    logic [31:0] w_crc_nx;
    logic [23:0] r_shift;
    logic [23:0] w_shift_nx;
    logic [4:0]  r_cnt;
    logic [4:0]  w_cnt_nx;
    logic [31:0] r_crc_out;
    logic [31:0] w_crc_out_nx;
    logic        r_valid;

    logic [31:0] w_word_crc;
    logic [31:0] w_bit_crc;
    logic        w_partial;
    logic [4:0]  w_tail_cnt;

    assign w_word_crc = crc32_24(r_crc, bus.s_data_i);
    assign w_bit_crc  = crc32_bit(r_crc, r_shift[23]);
    assign w_partial  = (bus.s_nbytes_i == 2'd1) || (bus.s_nbytes_i == 2'd2);
    assign w_tail_cnt = (bus.s_nbytes_i == 2'd1) ? 5'd8 : 5'd16;

    // Ready depends only on the state register and the reset input.
    assign bus.s_ready_o = (r_state == S_ACCUM) && !rst_i;
    assign bus.m_valid_o = r_valid;
    assign bus.m_crc_o   = r_crc_out;

    // Next-state and datapath decisions; everything holds unless a rule moves it.
    always_comb begin
        w_state_nx   = r_state;
        w_crc_nx     = r_crc;
        w_shift_nx   = r_shift;
        w_cnt_nx     = r_cnt;
        w_crc_out_nx = r_crc_out;
        case (r_state)
            S_ACCUM: begin
                if (bus.s_valid_i) begin
                    if (!bus.s_last_i) begin
                        w_crc_nx = w_word_crc;
                    end else if (w_partial) begin
                        // Partial last word: CRC untouched now, bits go serially.
                        w_shift_nx = bus.s_data_i;
                        w_cnt_nx   = w_tail_cnt;
                        w_state_nx = S_TAIL;
                    end else begin
                        w_crc_nx     = w_word_crc;
                        w_crc_out_nx = w_word_crc ^ XOROUT;
                        w_state_nx   = S_DONE;
                    end
                end else begin
                    w_state_nx = S_ACCUM;
                end
            end
            S_TAIL: begin
                w_crc_nx   = w_bit_crc;
                w_shift_nx = {r_shift[22:0], 1'b0};
                w_cnt_nx   = r_cnt - 5'd1;
                if (r_cnt <= 5'd1) begin
                    w_cnt_nx     = 5'd0;
                    w_crc_out_nx = w_bit_crc ^ XOROUT;
                    w_state_nx   = S_DONE;
                end else begin
                    w_state_nx = S_TAIL;
                end
            end
            S_DONE: begin
                if (bus.m_ready_i) begin
                    w_crc_nx     = INIT;
                    w_crc_out_nx = INIT ^ XOROUT;
                    w_state_nx   = S_ACCUM;
                end else begin
                    w_state_nx = S_DONE;
                end
            end
            default: begin
                w_state_nx   = S_ACCUM;
                w_crc_nx     = INIT;
                w_shift_nx   = 24'h00_0000;
                w_cnt_nx     = 5'd0;
                w_crc_out_nx = INIT ^ XOROUT;
            end
        endcase
    end

    // State, CRC, tail shifter and output registers; reset discards any frame.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= S_ACCUM;
            r_crc     <= INIT;
            r_shift   <= 24'h00_0000;
            r_cnt     <= 5'd0;
            r_crc_out <= INIT ^ XOROUT;
            r_valid   <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_crc     <= w_crc_nx;
            r_shift   <= w_shift_nx;
            r_cnt     <= w_cnt_nx;
            r_crc_out <= w_crc_out_nx;
            r_valid   <= (w_state_nx == S_DONE);
        end
    end

endmodule

// File: tb/tb_crc32_24_stream.sv
// Self-checking bench for crc32_24_stream: randomized framing, gaps and
// backpressure checked against a byte-wise CRC-32 reference model.
module tb_crc32_24_stream;

    localparam logic [31:0] POLY = 32'h04C11DB7;

    typedef logic [7:0] bq_t [$];

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_valid = 1'b0;
    logic [23:0] s_data = 24'h0;
    logic        s_last = 1'b0;
    logic [1:0]  s_nbytes = 2'd0;
    logic        m_ready = 1'b0;

    int n_pass  = 0;
    int n_total = 0;

    crc32_24_stream_if if0 ();
    crc32_24_stream_if if1 ();

    assign if0.s_valid_i  = s_valid;
    assign if0.s_data_i   = s_data;
    assign if0.s_last_i   = s_last;
    assign if0.s_nbytes_i = s_nbytes;
    assign if0.m_ready_i  = m_ready;
    assign if1.s_valid_i  = s_valid;
    assign if1.s_data_i   = s_data;
    assign if1.s_last_i   = s_last;
    assign if1.s_nbytes_i = s_nbytes;
    assign if1.m_ready_i  = m_ready;

    crc32_24_stream #(.INIT(32'hFFFFFFFF), .XOROUT(32'hFFFFFFFF)) u_dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (if0.slave)
    );

    crc32_24_stream #(.INIT(32'hFFFFFFFF), .XOROUT(32'h00000000)) u_dut_x0 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (if1.slave)
    );

    always #5 clk = ~clk;

    // Reference: CRC-32 over a byte string, each byte folded into the top of the register.
    function automatic logic [31:0] model_crc(input bq_t b, input logic [31:0] xo);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        foreach (b[i]) begin
            c = c ^ {b[i], 24'h000000};
            for (int k = 0; k < 8; k++) begin
                if (c[31]) c = (c << 1) ^ POLY;
                else       c = c << 1;
            end
        end
        return c ^ xo;
    endfunction

    function automatic bq_t ascii_digits(input int n);
        bq_t b;
        for (int i = 1; i <= n; i++) b.push_back(8'(8'h30 + i));
        return b;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one frame as 24-bit words; junk fills unused bytes of a short last word.
    task automatic send_frame(input bq_t b, input int gapmax, input bit big_gap,
                              output int last_n, output bit ok);
        int i;
        int w;
        i = 0; w = 0; ok = 1'b1; last_n = 0;
        while (i < b.size()) begin
            int n;
            int budget;
            logic [23:0] d;
            n = (b.size() - i >= 3) ? 3 : (b.size() - i);
            d = 24'($urandom);
            for (int k = 0; k < n; k++) d[23 - 8*k -: 8] = b[i + k];
            s_valid = 1'b0;
            if (gapmax > 0) repeat ($urandom_range(0, gapmax)) tick();
            if (big_gap && w == 1) repeat (10) tick();
            s_valid = 1'b1;
            s_data  = d;
            s_last  = (i + n >= b.size());
            if (!s_last)      s_nbytes = 2'($urandom);
            else if (n == 3)  s_nbytes = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'd3;
            else              s_nbytes = 2'(n);
            budget = 0;
            while (!if0.s_ready_o && budget < 50) begin
                tick();
                budget++;
            end
            if (!if0.s_ready_o) ok = 1'b0;
            tick();
            s_valid = 1'b0;
            s_last  = 1'b0;
            i += n;
            w++;
            last_n = n;
        end
    endtask

    // Counts edges after the last accept until m_valid shows, noting any ready high.
    task automatic wait_result(output int lat, output bit seen, output bit rdy_low);
        lat = 0;
        rdy_low = 1'b1;
        while (!if0.m_valid_o && lat < 40) begin
            if (if0.s_ready_o) rdy_low = 1'b0;
            tick();
            lat++;
        end
        seen = if0.m_valid_o;
        if (if0.s_ready_o) rdy_low = 1'b0;
    endtask

    // Holds the consumer off for 'hold' cycles, then takes the CRC.
    task automatic handshake(input int hold, output bit stable, output logic [31:0] crc_after,
                             output bit v_after, output bit r_after);
        logic [31:0] c0;
        c0 = if0.m_crc_o;
        stable = 1'b1;
        repeat (hold) begin
            tick();
            if (!if0.m_valid_o || if0.m_crc_o !== c0 || if0.s_ready_o) stable = 1'b0;
        end
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        v_after   = if0.m_valid_o;
        r_after   = if0.s_ready_o;
        crc_after = if0.m_crc_o;
    endtask

    // One complete frame: send, latency, both CRC flavours, backpressure, handshake.
    task automatic test_frame(input string name, input bq_t b, input int gapmax, input bit big_gap,
                              input int hold, input logic [31:0] exp_crc);
        int ln, lat, exp_lat;
        bit ok, seen, rdy_low, stable, v_a, r_a;
        logic [31:0] c_a;
        send_frame(b, gapmax, big_gap, ln, ok);
        n_total++;
        if (!ok) $display("FAIL %s accept: word not accepted within 50 cycles", name);
        else n_pass++;
        wait_result(lat, seen, rdy_low);
        exp_lat = (ln == 3) ? 0 : 8 * ln;
        n_total++;
        if (!seen || lat != exp_lat)
            $display("FAIL %s latency: got %0d cycles (valid=%0b), expected %0d", name, lat, seen, exp_lat);
        else n_pass++;
        n_total++;
        if (!rdy_low) $display("FAIL %s ready_low: s_ready_o seen 1, expected 0 until handshake", name);
        else n_pass++;
        n_total++;
        if (if0.m_crc_o !== exp_crc)
            $display("FAIL %s crc: got %08h expected %08h", name, if0.m_crc_o, exp_crc);
        else n_pass++;
        n_total++;
        if (if1.m_crc_o !== (exp_crc ^ 32'hFFFFFFFF))
            $display("FAIL %s crc_xorout0: got %08h expected %08h", name, if1.m_crc_o, exp_crc ^ 32'hFFFFFFFF);
        else n_pass++;
        handshake(hold, stable, c_a, v_a, r_a);
        if (hold > 0) begin
            n_total++;
            if (!stable) $display("FAIL %s hold: output changed or ready high while held, expected stable", name);
            else n_pass++;
        end
        n_total++;
        if (v_a !== 1'b0 || r_a !== 1'b1 || c_a !== 32'h00000000)
            $display("FAIL %s handshake: valid=%0b ready=%0b crc=%08h expected 0 1 00000000", name, v_a, r_a, c_a);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        n_total++;
        if (if0.s_ready_o !== 1'b0 || if0.m_valid_o !== 1'b0)
            $display("FAIL reset_held: ready=%0b valid=%0b expected 0 0", if0.s_ready_o, if0.m_valid_o);
        else n_pass++;
        rst = 1'b0;
        #1;
        n_total++;
        if (if0.s_ready_o !== 1'b1 || if0.m_valid_o !== 1'b0 || if0.m_crc_o !== 32'h00000000 ||
            if1.m_crc_o !== 32'hFFFFFFFF)
            $display("FAIL reset_state: ready=%0b valid=%0b crc=%08h crc_x0=%08h expected 1 0 00000000 ffffffff",
                     if0.s_ready_o, if0.m_valid_o, if0.m_crc_o, if1.m_crc_o);
        else n_pass++;
    endtask

    task automatic test_full_word();
        test_frame("full_9", ascii_digits(9), 0, 1'b0, 0, 32'hFC891918);
    endtask

    task automatic test_partial();
        test_frame("partial_8", ascii_digits(8), 0, 1'b0, 0, model_crc(ascii_digits(8), 32'hFFFFFFFF));
        test_frame("partial_7", ascii_digits(7), 0, 1'b0, 0, model_crc(ascii_digits(7), 32'hFFFFFFFF));
    endtask

    task automatic test_backpressure();
        test_frame("bp_hold", ascii_digits(9), 0, 1'b0, 5, 32'hFC891918);
        test_frame("bp_again", ascii_digits(9), 0, 1'b0, 0, 32'hFC891918);
    endtask

    task automatic test_gaps();
        test_frame("gaps_9", ascii_digits(9), 3, 1'b1, 0, 32'hFC891918);
        test_frame("gaps_8", ascii_digits(8), 4, 1'b1, 2, model_crc(ascii_digits(8), 32'hFFFFFFFF));
        test_frame("gaps_7", ascii_digits(7), 2, 1'b1, 1, model_crc(ascii_digits(7), 32'hFFFFFFFF));
    endtask

    // Pulses reset for one edge and checks the frame is dropped without a CRC.
    task automatic pulse_reset_and_check(input string name);
        int rises;
        rst = 1'b1;
        #1;
        n_total++;
        if (if0.s_ready_o !== 1'b0) $display("FAIL %s ready_in_reset: got %0b expected 0", name, if0.s_ready_o);
        else n_pass++;
        tick();
        rst = 1'b0;
        #1;
        n_total++;
        if (if0.s_ready_o !== 1'b1 || if0.m_valid_o !== 1'b0 || if0.m_crc_o !== 32'h00000000)
            $display("FAIL %s after_reset: ready=%0b valid=%0b crc=%08h expected 1 0 00000000",
                     name, if0.s_ready_o, if0.m_valid_o, if0.m_crc_o);
        else n_pass++;
        rises = 0;
        repeat (30) begin
            tick();
            if (if0.m_valid_o) rises++;
        end
        n_total++;
        if (rises != 0) $display("FAIL %s no_crc: valid high %0d cycles, expected 0", name, rises);
        else n_pass++;
    endtask

    task automatic test_reset_tail();
        int ln;
        bit ok;
        send_frame(ascii_digits(8), 0, 1'b0, ln, ok);
        repeat (5) tick();
        pulse_reset_and_check("rst_tail");
        test_frame("rst_tail_next", ascii_digits(9), 0, 1'b0, 0, 32'hFC891918);
    endtask

    task automatic test_reset_done();
        int ln, lat;
        bit ok, seen, rdy_low;
        send_frame(ascii_digits(9), 0, 1'b0, ln, ok);
        wait_result(lat, seen, rdy_low);
        n_total++;
        if (!seen) $display("FAIL rst_done_reach: valid=%0b expected 1 before reset", seen);
        else n_pass++;
        tick();
        pulse_reset_and_check("rst_done");
        test_frame("rst_done_next", ascii_digits(9), 0, 1'b0, 0, 32'hFC891918);
    endtask

    task automatic test_random();
        for (int f = 0; f < 12; f++) begin
            bq_t b;
            int len;
            len = $urandom_range(1, 20);
            for (int i = 0; i < len; i++) b.push_back(8'($urandom));
            test_frame($sformatf("rand_%0d", f), b, $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                       $urandom_range(0, 4), model_crc(b, 32'hFFFFFFFF));
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_full_word();
        test_partial();
        test_backpressure();
        test_gaps();
        test_reset_tail();
        test_reset_done();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
